// File: rtl/arm_pipelined_cond_unit.sv
// Execute-stage condition unit: evaluates the ARM condition field against the stored NZCV flags,
// gates the write/branch controls, updates the flags and counts executed/skipped instructions.
module arm_pipelined_cond_unit #(
    parameter int CntWidth = 16
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    input  logic                i_Valid,
    input  logic                i_Stall,
    input  logic                i_Flush,
    input  logic [3:0]          i_Cond,
    input  logic [3:0]          i_ALU_Flags,
    input  logic [1:0]          i_FlagWrite,
    input  logic                i_RegWrite,
    input  logic                i_MemWrite,
    input  logic                i_PCSrc,
    output logic                o_RegWrite,
    output logic                o_MemWrite,
    output logic                o_PCSrc,
    output logic                o_CondEx,
    output logic                o_Cond_Undef,
    output logic [3:0]          o_Flags,
    output logic [CntWidth-1:0] o_Exec_Count,
    output logic [CntWidth-1:0] o_Skip_Count
);

    logic [3:0]          r_flags;
    logic [CntWidth-1:0] r_exec_cnt;
    logic [CntWidth-1:0] r_skip_cnt;

    logic w_live;
    logic w_cond_pass;
    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_live = i_Valid & ~i_Stall & ~i_Flush;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluated against the stored flags only; the ALU flags of this instruction land next cycle.
    always_comb begin
        w_cond_pass = 1'b0;
        case (i_Cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign o_CondEx     = w_live & w_cond_pass;
    assign o_Cond_Undef = w_live & (i_Cond == 4'b1111);
    assign o_RegWrite   = i_RegWrite & o_CondEx;
    assign o_MemWrite   = i_MemWrite & o_CondEx;
    assign o_PCSrc      = i_PCSrc & o_CondEx;
    assign o_Flags      = r_flags;
    assign o_Exec_Count = r_exec_cnt;
    assign o_Skip_Count = r_skip_cnt;

    always_ff @(posedge i_CLK) begin
        if (!i_NRESET) begin
            r_flags    <= 4'b0000;
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_live) begin
            if (o_CondEx) begin
                if (i_FlagWrite[1]) r_flags[3:2] <= i_ALU_Flags[3:2];
                if (i_FlagWrite[0]) r_flags[1:0] <= i_ALU_Flags[1:0];
                if (r_exec_cnt != '1) r_exec_cnt <= r_exec_cnt + CntWidth'(1);
            end else if (r_skip_cnt != '1) begin
                r_skip_cnt <= r_skip_cnt + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_arm_pipelined_cond_unit.sv
// Bench for arm_pipelined_cond_unit: table of condition-code vectors plus directed multi-cycle sequences.
module tb_arm_pipelined_cond_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic          valid, stall, flush;
    logic [3:0]    cond, alu_flags;
    logic [1:0]    flag_write;
    logic          reg_w, mem_w, pc_src;
    logic          o_reg_w, o_mem_w, o_pc_src, o_cond_ex, o_undef;
    logic [3:0]    o_flags;
    logic [CW-1:0] o_exec, o_skip;

    int n_tests = 0;
    int n_fail  = 0;

    arm_pipelined_cond_unit #(.CntWidth(CW)) dut (
        .i_CLK        (clk),
        .i_NRESET     (nreset),
        .i_Valid      (valid),
        .i_Stall      (stall),
        .i_Flush      (flush),
        .i_Cond       (cond),
        .i_ALU_Flags  (alu_flags),
        .i_FlagWrite  (flag_write),
        .i_RegWrite   (reg_w),
        .i_MemWrite   (mem_w),
        .i_PCSrc      (pc_src),
        .o_RegWrite   (o_reg_w),
        .o_MemWrite   (o_mem_w),
        .o_PCSrc      (o_pc_src),
        .o_CondEx     (o_cond_ex),
        .o_Cond_Undef (o_undef),
        .o_Flags      (o_flags),
        .o_Exec_Count (o_exec),
        .o_Skip_Count (o_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       rw, mw, pc;
        logic       exp_ex;
        logic       exp_undef;
    } vec_t;

    vec_t vecs[22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] c,
                         input logic [3:0] alu, input logic [1:0] fw,
                         input logic rw, input logic mw, input logic pc);
        valid = v; stall = s; flush = f; cond = c;
        alu_flags = alu; flag_write = fw; reg_w = rw; mem_w = mw; pc_src = pc;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        nreset = 1'b1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        drive(1'b1, 1'b0, 1'b0, 4'he, f, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        //        cond     flags    rw    mw    pc    ex    undef
        vecs[0]  = '{4'h0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{4'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'h1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'h1, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'h2, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'h3, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'h4, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{4'h5, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'h6, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'h7, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'h8, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'h8, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'h9, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'h9, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'ha, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{4'ha, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{4'hb, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{4'hc, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{4'hc, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{4'hd, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{4'he, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{4'hf, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        nreset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        nreset = 1'b1;

        // Reset state and first skipped EQ instruction
        chk("reset_flags", o_flags, 4'b0000);
        chk("reset_exec", o_exec, 0);
        chk("reset_skip", o_skip, 0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("eq_after_reset_ex", o_cond_ex, 1'b0);
        tick();
        chk("eq_after_reset_skip", o_skip, 1);
        chk("eq_after_reset_flags", o_flags, 4'b0000);

        // Condition-code table
        for (int i = 0; i < 22; i++) begin
            do_reset();
            load_flags(vecs[i].flags);
            chk($sformatf("v%0d_flags", i), o_flags, vecs[i].flags);
            drive(1'b1, 1'b0, 1'b0, vecs[i].cond, 4'h0, 2'b00, vecs[i].rw, vecs[i].mw, vecs[i].pc);
            #1;
            chk($sformatf("v%0d_condex", i), o_cond_ex, vecs[i].exp_ex);
            chk($sformatf("v%0d_regw", i), o_reg_w, vecs[i].rw & vecs[i].exp_ex);
            chk($sformatf("v%0d_memw", i), o_mem_w, vecs[i].mw & vecs[i].exp_ex);
            chk($sformatf("v%0d_pcsrc", i), o_pc_src, vecs[i].pc & vecs[i].exp_ex);
            chk($sformatf("v%0d_undef", i), o_undef, vecs[i].exp_undef);
        end

        // AL sets Z, the very next EQ sees it
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'he, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("al_load_flags", o_flags, 4'b0100);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("b2b_eq_condex", o_cond_ex, 1'b1);
        chk("b2b_eq_regw", o_reg_w, 1'b1);
        reg_w = 1'b0;
        #1;
        chk("b2b_eq_regw0", o_reg_w, 1'b0);
        tick();
        chk("b2b_exec", o_exec, 2);

        // Partial flag write: only N,Z
        drive(1'b1, 1'b0, 1'b0, 4'he, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fw10_flags", o_flags, 4'b1000);

        // Failed NE with flag write requested
        load_flags(4'b0100);
        drive(1'b1, 1'b0, 1'b0, 4'h1, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
        #1;
        chk("ne_fail_condex", o_cond_ex, 1'b0);
        chk("ne_fail_gated", {o_reg_w, o_mem_w, o_pc_src}, 3'b000);
        tick();
        chk("ne_fail_flags", o_flags, 4'b0100);
        chk("ne_fail_skip", o_skip, 1);
        chk("ne_fail_exec", o_exec, 4);

        // Stall, flush, both, and invalid slot: nothing changes
        for (int k = 0; k < 4; k++) begin
            drive(k != 3, (k == 0) || (k == 2), (k == 1) || (k == 2), 4'he, 4'b1010, 2'b11,
                  1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("hold%0d_condex", k), o_cond_ex, 1'b0);
            chk($sformatf("hold%0d_gated", k), {o_reg_w, o_mem_w, o_pc_src}, 3'b000);
            tick();
            chk($sformatf("hold%0d_flags", k), o_flags, 4'b0100);
            chk($sformatf("hold%0d_cnts", k), {o_exec, o_skip}, {4'd4, 4'd1});
        end

        // Undefined condition counts as skipped
        drive(1'b1, 1'b0, 1'b0, 4'hf, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0);
        #1;
        chk("undef_flag", o_undef, 1'b1);
        tick();
        chk("undef_skip", o_skip, 2);
        chk("undef_flags", o_flags, 4'b0100);

        // Reset mid-operation discards the pending flag update
        nreset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'he, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
        tick();
        chk("midrst_flags", o_flags, 4'b0000);
        chk("midrst_cnts", {o_exec, o_skip}, 8'h00);
        nreset = 1'b1;

        // Counter saturation
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
            tick();
            if (k == 14) chk("exec_at_15", o_exec, 4'hE + 4'h1);
        end
        chk("exec_sat", o_exec, 4'hF);
        tick();
        chk("exec_sat_hold", o_exec, 4'hF);
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'hf, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("skip_sat", o_skip, 4'hF);
        nreset = 1'b0;
        tick();
        chk("sat_reset", {o_exec, o_skip}, 8'h00);
        nreset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_pipelined_cond_unit.md
ARM_PIPELINED_COND_UNIT -- requirements
Module: arm_pipelined_cond_unit

Interface
REQ-001 SHALL have parameter CntWidth, default 16, width of the executed/skipped instruction counters.
REQ-002 SHALL have port i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_NRESET  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_Valid  input  1  execute-stage slot holds a real instruction.
REQ-005 SHALL have port i_Stall  input  1  execute stage held this cycle; instruction re-presented next cycle.
REQ-006 SHALL have port i_Flush  input  1  execute-stage instruction squashed this cycle.
REQ-007 SHALL have port i_Cond  input  4  ARM condition field of the execute-stage instruction.
REQ-008 SHALL have port i_ALU_Flags  input  4  {N,Z,C,V} from the ALU for the same instruction.
REQ-009 SHALL have port i_FlagWrite  input  2  bit1 enables N,Z update; bit0 enables C,V update.
REQ-010 SHALL have ports i_RegWrite, i_MemWrite, i_PCSrc  input  1 each  ungated control from decode.
REQ-011 SHALL have ports o_RegWrite, o_MemWrite, o_PCSrc  output  1 each  condition-gated controls.
REQ-012 SHALL have port o_CondEx  output  1  condition passed for the current instruction.
REQ-013 SHALL have port o_Cond_Undef  output  1  i_Cond = 4'b1111 on a live instruction.
REQ-014 SHALL have port o_Flags  output  4  stored {N,Z,C,V} register.
REQ-015 SHALL have ports o_Exec_Count, o_Skip_Count  output  CntWidth each  executed / condition-failed instruction counters.

Function
REQ-016 SHALL define live = i_Valid & ~i_Stall & ~i_Flush.
REQ-017 SHALL evaluate o_CondEx combinationally from i_Cond and o_Flags (stored flags, not i_ALU_Flags): EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
REQ-018 SHALL drive o_CondEx = 0 whenever live = 0.
REQ-019 SHALL drive o_RegWrite/o_MemWrite/o_PCSrc = corresponding input AND o_CondEx, zero latency.
REQ-020 SHALL drive o_Cond_Undef = live & (i_Cond == 4'b1111), combinational.
REQ-021 SHALL, on a clock edge with live & o_CondEx & i_FlagWrite[1], load N,Z from i_ALU_Flags[3:2]; same with i_FlagWrite[0] for C,V from i_ALU_Flags[1:0]; otherwise hold each pair.
REQ-022 SHALL make updated flags visible on o_Flags and to condition evaluation from the next cycle (one-cycle latency; back-to-back dependent instructions see the new flags).
REQ-023 SHALL take ALU flags as presented, with no inversion or reinterpretation of C.
REQ-024 SHALL increment o_Exec_Count on each edge with live & o_CondEx.
REQ-025 SHALL increment o_Skip_Count on each edge with live & ~o_CondEx (includes cond 1111).
REQ-026 SHALL saturate both counters at all-ones; no wrap-around.
REQ-027 SHALL hold flags and counters on any edge with i_Stall or i_Flush; i_Flush and i_Stall together behave as i_Flush.
REQ-028 SHALL ignore i_FlagWrite, i_ALU_Flags and control inputs when live = 0.

Reset
REQ-029 SHALL, on an edge with i_NRESET = 0, set o_Flags = 4'b0000 and both counters = 0, overriding all other inputs.
REQ-030 SHALL, during reset, keep combinational outputs driven from the reset-state flags (registered state 0 from the first reset edge).
REQ-031 SHALL, on a reset asserted mid-operation, discard any pending flag update in that cycle.

Verification
REQ-032 SHALL cover: reset, then i_Cond=EQ(0000), live -> o_CondEx=0, o_Skip_Count=1, o_Flags=0000.
REQ-033 SHALL cover: AL, i_FlagWrite=11, i_ALU_Flags=0100 -> next cycle o_Flags=0100; following EQ instruction -> o_CondEx=1, o_RegWrite follows i_RegWrite.
REQ-034 SHALL cover: i_FlagWrite=10 with i_ALU_Flags=1011 from flags 0100 -> o_Flags=1000 (C,V held).
REQ-035 SHALL cover: NE with Z=1 and i_FlagWrite=11 -> o_CondEx=0, flags unchanged, gated outputs 0.
REQ-036 SHALL cover: i_Stall=1 then i_Flush=1 with AL, FlagWrite=11 -> flags and counters unchanged, o_CondEx=0 both cycles.
REQ-037 SHALL cover: CntWidth=4, 17 live AL instructions -> o_Exec_Count=4'hF, stays 4'hF; i_NRESET=0 one edge -> 0.
